// File: rtl/metadata_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : metadata_arbiter
//  Purpose  : Round-robin arbiter that turns per-lane metadata request pulses
//             into single-cycle memory reads of {lane id, lane pointer}, then
//             captures the read data into a per-lane slot and flags it fresh.
//  Ports    : clk, reset (async, active-low), song_reset (sync restart),
//             pause (blocks new grants), metadata_request[NREQ] (pulses),
//             mem_rd_data[DW] (read data, MEM_LAT cycles after mem_rd_en),
//             mem_rd_en / mem_addr (read strobe and address),
//             metadata_link[NREQ*DW] (slot data), metadata_available[NREQ],
//             busy (anything pending, in flight, or draining).
//  Revision : 1.0  initial release
// ============================================================================
module metadata_arbiter #(
    parameter int NREQ    = 37,
    parameter int DW      = 16,
    parameter int PW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 song_reset,
    input  logic                 pause,
    input  logic [NREQ-1:0]      metadata_request,
    input  logic [DW-1:0]        mem_rd_data,
    output logic                 mem_rd_en,
    output logic [6+PW-1:0]      mem_addr,
    output logic [NREQ*DW-1:0]   metadata_link,
    output logic [NREQ-1:0]      metadata_available,
    output logic                 busy
);

    localparam int IDW = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     pending_q, pending_d;
    logic [NREQ-1:0]     avail_q, avail_d;
    logic [PW-1:0]       ptr_q [NREQ];
    logic [PW-1:0]       ptr_d [NREQ];
    logic [DW-1:0]       slot_q [NREQ];
    logic [DW-1:0]       slot_d [NREQ];
    logic [IDW-1:0]      last_q, last_d;
    logic                rd_en_q, rd_en_d;
    logic [IDW+PW-1:0]   addr_q, addr_d;
    // In-flight tracker: entry j is valid during the (j+1)-th cycle after the
    // read strobe, so the last stage lines up with the returning data.
    logic [MEM_LAT-1:0]  pipe_vld_q, pipe_vld_d;
    logic [IDW-1:0]      pipe_id_q [MEM_LAT];
    logic [IDW-1:0]      pipe_id_d [MEM_LAT];
    logic                busy_q, busy_d;

    logic [NREQ-1:0]     w_req_eff;
    logic [NREQ-1:0]     w_cand;
    logic                w_can_grant;
    logic                w_gnt_vld;
    logic [IDW-1:0]      w_gnt_id;
    logic                w_del_wr;
    logic [IDW-1:0]      w_del_id;
    logic                w_inflight;
    logic                w_inflight_nxt;

    // Index visited at search offset k, starting just after the last grant.
    function automatic int rr_idx(input logic [IDW-1:0] last, input int k);
        int i;
        i = int'(last) + 1 + k;
        if (i >= NREQ) i = i - NREQ;
        return i;
    endfunction

    always_comb begin
        // Pulses are dropped while draining after a song restart.
        w_req_eff   = (state_q != ST_FLUSH && !song_reset) ? metadata_request : '0;
        w_cand      = pending_q | w_req_eff;
        w_can_grant = !pause && !song_reset && (state_q != ST_FLUSH);

        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_can_grant && !w_gnt_vld && w_cand[rr_idx(last_q, k)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = IDW'(rr_idx(last_q, k));
            end
        end

        w_inflight = rd_en_q | (|pipe_vld_q);
        w_del_id   = pipe_id_q[MEM_LAT-1];
        w_del_wr   = pipe_vld_q[MEM_LAT-1] && (state_q != ST_FLUSH) && !song_reset;

        pending_d = w_cand;
        avail_d   = avail_q;
        ptr_d     = ptr_q;
        slot_d    = slot_q;
        last_d    = last_q;
        rd_en_d   = w_gnt_vld;
        addr_d    = addr_q;

        if (w_del_wr) begin
            slot_d[w_del_id]  = mem_rd_data;
            avail_d[w_del_id] = 1'b1;
        end

        // A grant after a delivery to the same lane wins: the returning data
        // belongs to an older read than the one just issued.
        if (w_gnt_vld) begin
            pending_d[w_gnt_id] = 1'b0;
            avail_d[w_gnt_id]   = 1'b0;
            ptr_d[w_gnt_id]     = ptr_q[w_gnt_id] + PW'(1);
            last_d              = w_gnt_id;
            addr_d              = {w_gnt_id, ptr_q[w_gnt_id]};
        end

        if (song_reset) begin
            pending_d = '0;
            avail_d   = '0;
            for (int k = 0; k < NREQ; k++) ptr_d[k] = '0;
        end

        pipe_vld_d[0] = rd_en_q;
        pipe_id_d[0]  = addr_q[PW +: IDW];
        for (int j = 1; j < MEM_LAT; j++) begin
            pipe_vld_d[j] = pipe_vld_q[j-1];
            pipe_id_d[j]  = pipe_id_q[j-1];
        end
        w_inflight_nxt = rd_en_d | (|pipe_vld_d);

        state_d = state_q;
        if (song_reset) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_FLUSH: if (!w_inflight) state_d = ST_IDLE;
                ST_IDLE:  if ((|w_cand) && !pause) state_d = ST_RUN;
                ST_RUN:   if (!(|pending_d) && !w_inflight_nxt) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE) | (|pending_d) | w_inflight_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            avail_q    <= '0;
            last_q     <= IDW'(NREQ - 1);
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            pipe_vld_q <= '0;
            busy_q     <= 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                ptr_q[k]  <= '0;
                slot_q[k] <= '0;
            end
            for (int j = 0; j < MEM_LAT; j++) pipe_id_q[j] <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            avail_q    <= avail_d;
            last_q     <= last_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            pipe_vld_q <= pipe_vld_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            slot_q     <= slot_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    assign mem_rd_en          = rd_en_q;
    assign mem_addr           = addr_q;
    assign metadata_available = avail_q;
    assign busy               = busy_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_link
        assign metadata_link[i*DW +: DW] = slot_q[i];
    end

endmodule
`default_nettype wire
